// File: rtl/mcs4_pkg.sv
// Shared definitions for the MCS-4 fetch sequencer.
//   - state_idx_t : cycle state index (A1..An = 0..n-1, then M1, M2, X1, X2, X3)
//   - A_FIRST     : index of A1
//   - OFS_*       : offsets of the M/X states relative to ADDR_NIBBLES
//   - pc_width()  : program counter width for a given nibble width / count
package mcs4_pkg;

  localparam int DW_DEFAULT           = 4;
  localparam int ADDR_NIBBLES_DEFAULT = 3;

  // Four bits covers up to 11 address nibbles plus the five M/X states.
  typedef logic [3:0] state_idx_t;

  localparam state_idx_t A_FIRST = 4'd0;

  // M1 = ADDR_NIBBLES, M2 = ADDR_NIBBLES+1, ... X3 = ADDR_NIBBLES+4
  localparam int OFS_M1 = 0;
  localparam int OFS_M2 = 1;
  localparam int OFS_X1 = 2;
  localparam int OFS_X2 = 3;
  localparam int OFS_X3 = 4;

  function automatic int pc_width(input int dw, input int nibbles);
    return dw * nibbles;
  endfunction

  function automatic state_idx_t state_after_addr(input int nibbles, input int ofs);
    return state_idx_t'(nibbles + ofs);
  endfunction

endpackage

// File: rtl/mcs4_addr_stack.sv
// Circular return-address stack.
//   clk_i, rst_ni : clock, async active-low reset (all entries and sp cleared)
//   push_i        : write data_i at sp, advance sp (wraps, oldest entry lost)
//   pop_i         : step sp back (wraps); pop wins over push
//   data_i        : address to push
//   top_o         : entry at sp-1, i.e. the value a pop returns
module mcs4_addr_stack #(
  parameter int W           = 12,
  parameter int STACK_DEPTH = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o
);

  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW-1:0] LAST = SPW'(STACK_DEPTH - 1);

  logic [W-1:0]   mem_q [STACK_DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_inc;
  logic [SPW-1:0] sp_dec;

  assign sp_inc = (sp_q == LAST) ? '0 : sp_q + SPW'(1);
  assign sp_dec = (sp_q == '0) ? LAST : sp_q - SPW'(1);

  // An empty stack simply returns whatever sits below sp; no underflow flag.
  assign top_o = mem_q[sp_dec];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      sp_q <= '0;
    end else if (pop_i) begin
      sp_q <= sp_dec;
    end else if (push_i) begin
      mem_q[sp_q] <= data_i;
      sp_q        <= sp_inc;
    end
  end

endmodule

// File: rtl/mcs4_fetch_sequencer.sv
// MCS-4 instruction-cycle sequencer: program counter, return stack, address
// drive, opcode latch and SYNC / CM-ROM / CM-RAM generation.
//   clk_i, RESET_ni      : clock, async active-low reset
//   phi2_i               : phase-2 clock, sampled; each rising edge advances one state
//   d_i / d_o / d_oe_o   : data bus in, address nibble out, output enable
//   sync_o               : low in X3
//   cm_rom_o, cm_ram_o   : ROM strobe in An; bank strobe in An and (SRC) X2
//   opr_o, opa_o         : latched opcode nibbles; instr_valid_o pulses after M2
//   jump_i, jump_addr_i, push_i, pop_i : PC control sampled on X3 -> A1
//   dcl_i, dcl_bank_i    : bank select load, sampled while in X3
//   src_i                : sampled on entry to X2
//
// state       | meaning
// ------------+-----------------------------------------------
// A1..An      | drive PC nibble k on the bus (An: CM-ROM/CM-RAM)
// M1          | opcode high nibble on the bus
// M2          | opcode low nibble on the bus
// X1          | execute
// X2          | execute; PC incremented on entry; SRC bank strobe
// X3          | SYNC low; PC control and DCL sampling; reset state
module mcs4_fetch_sequencer
  import mcs4_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int ADDR_NIBBLES = ADDR_NIBBLES_DEFAULT,
  parameter int STACK_DEPTH  = 3,
  parameter int NUM_CM_RAM   = 4
) (
  input  logic                            clk_i,
  input  logic                            RESET_ni,
  input  logic                            phi2_i,
  input  logic [DW-1:0]                   d_i,
  output logic [DW-1:0]                   d_o,
  output logic                            d_oe_o,
  output logic                            sync_o,
  output logic                            cm_rom_o,
  output logic [NUM_CM_RAM-1:0]           cm_ram_o,
  output logic [DW-1:0]                   opr_o,
  output logic [DW-1:0]                   opa_o,
  output logic                            instr_valid_o,
  input  logic                            jump_i,
  input  logic [DW*ADDR_NIBBLES-1:0]      jump_addr_i,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic                            dcl_i,
  input  logic [$clog2(NUM_CM_RAM)-1:0]   dcl_bank_i,
  input  logic                            src_i
);

  localparam int PW = pc_width(DW, ADDR_NIBBLES);
  localparam int BW = $clog2(NUM_CM_RAM);

  localparam state_idx_t S_AN = state_idx_t'(ADDR_NIBBLES - 1);
  localparam state_idx_t S_M1 = state_after_addr(ADDR_NIBBLES, OFS_M1);
  localparam state_idx_t S_M2 = state_after_addr(ADDR_NIBBLES, OFS_M2);
  localparam state_idx_t S_X1 = state_after_addr(ADDR_NIBBLES, OFS_X1);
  localparam state_idx_t S_X2 = state_after_addr(ADDR_NIBBLES, OFS_X2);
  localparam state_idx_t S_X3 = state_after_addr(ADDR_NIBBLES, OFS_X3);

  state_idx_t      state_q, state_d;
  logic            phi2_q, phi2_qq;
  logic            adv;
  logic [PW-1:0]   pc_q;
  logic [BW-1:0]   bank_q;
  logic            src_q;
  logic [NUM_CM_RAM-1:0] bank_onehot;
  logic            leave_x3;
  logic            stk_push, stk_pop;
  logic [PW-1:0]   stk_top;

  // Edge is detected on the registered samples so advancement lands one clk
  // after the rising phi2 sample.
  assign adv      = phi2_q & ~phi2_qq;
  assign leave_x3 = adv && (state_q == S_X3);
  assign stk_pop  = leave_x3 && pop_i;
  assign stk_push = leave_x3 && !pop_i && jump_i && push_i;

  mcs4_addr_stack #(
    .W           (PW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i  (clk_i),
    .rst_ni (RESET_ni),
    .push_i (stk_push),
    .pop_i  (stk_pop),
    .data_i (pc_q),
    .top_o  (stk_top)
  );

  always_comb begin
    state_d = state_q;
    if (adv) state_d = (state_q == S_X3) ? A_FIRST : state_q + state_idx_t'(1);
  end

  always_comb begin
    d_o         = '0;
    d_oe_o      = 1'b0;
    bank_onehot = '0;
    for (int b = 0; b < NUM_CM_RAM; b++) bank_onehot[b] = (bank_q == BW'(b));
    for (int k = 0; k < ADDR_NIBBLES; k++) begin
      if (state_q == A_FIRST + state_idx_t'(k)) begin
        d_oe_o = 1'b1;
        d_o    = pc_q[k*DW +: DW];
      end
    end
    sync_o   = (state_q != S_X3);
    cm_rom_o = (state_q == S_AN);
    cm_ram_o = '0;
    if (state_q == S_AN || (state_q == S_X2 && src_q)) cm_ram_o = bank_onehot;
  end

  always_ff @(posedge clk_i or negedge RESET_ni) begin
    if (!RESET_ni) begin
      state_q       <= S_X3;
      phi2_q        <= 1'b0;
      phi2_qq       <= 1'b0;
      pc_q          <= '0;
      bank_q        <= '0;
      src_q         <= 1'b0;
      opr_o         <= '0;
      opa_o         <= '0;
      instr_valid_o <= 1'b0;
    end else begin
      phi2_q        <= phi2_i;
      phi2_qq       <= phi2_q;
      state_q       <= state_d;
      instr_valid_o <= adv && (state_q == S_M2);
      if (state_q == S_X3 && dcl_i) bank_q <= dcl_bank_i;
      if (adv) begin
        case (state_q)
          S_M1: opr_o <= d_i;
          S_M2: opa_o <= d_i;
          S_X1: begin
            pc_q  <= pc_q + PW'(1);
            src_q <= src_i;
          end
          S_X3: begin
            if (pop_i)       pc_q <= stk_top;
            else if (jump_i) pc_q <= jump_addr_i;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcs4_fetch_sequencer.sv
module tb_mcs4_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        RESET_ni;
  logic        phi2_i;
  logic [3:0]  d_i;
  logic [3:0]  d_o;
  logic        d_oe_o;
  logic        sync_o;
  logic        cm_rom_o;
  logic [3:0]  cm_ram_o;
  logic [3:0]  opr_o;
  logic [3:0]  opa_o;
  logic        instr_valid_o;
  logic        jump_i;
  logic [11:0] jump_addr_i;
  logic        push_i;
  logic        pop_i;
  logic        dcl_i;
  logic [1:0]  dcl_bank_i;
  logic        src_i;

  always #5 clk_i = ~clk_i;

  mcs4_fetch_sequencer dut (
    .clk_i         (clk_i),
    .RESET_ni      (RESET_ni),
    .phi2_i        (phi2_i),
    .d_i           (d_i),
    .d_o           (d_o),
    .d_oe_o        (d_oe_o),
    .sync_o        (sync_o),
    .cm_rom_o      (cm_rom_o),
    .cm_ram_o      (cm_ram_o),
    .opr_o         (opr_o),
    .opa_o         (opa_o),
    .instr_valid_o (instr_valid_o),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .dcl_i         (dcl_i),
    .dcl_bank_i    (dcl_bank_i),
    .src_i         (src_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int iv_cnt   = 0;

  // Reference model: the architectural state the specification talks about.
  logic [11:0] m_pc;
  logic [11:0] m_stack [3];
  int          m_sp;
  logic [1:0]  m_bank;

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 3; i++) m_stack[i] = '0;
    m_sp   = 0;
    m_bank = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] obs_bus();
    return {d_oe_o, d_o, sync_o, cm_rom_o, cm_ram_o};
  endfunction

  function automatic logic [10:0] exp_bus(input logic oe, input logic [3:0] d,
                                          input logic sync, input logic rom,
                                          input logic [3:0] ram);
    return {oe, d, sync, rom, ram};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] b);
    logic [3:0] one;
    one = 4'b0001;
    return one << b;
  endfunction

  task automatic phi2_edge();
    phi2_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (instr_valid_o === 1'b1) iv_cnt++;
    end
    phi2_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      if (instr_valid_o === 1'b1) iv_cnt++;
    end
  endtask

  // Runs one full cycle starting in X3 and ending in X3.
  task automatic run_cycle(input logic [3:0] op_hi, input logic [3:0] op_lo,
                           input logic src, input logic jmp, input logic psh,
                           input logic pp, input logic [11:0] jaddr,
                           input logic dcl, input logic [1:0] dbank);
    logic [3:0] nib;
    jump_i = jmp; push_i = psh; pop_i = pp; jump_addr_i = jaddr;
    dcl_i = dcl; dcl_bank_i = dbank;
    phi2_edge();
    if (pp) begin
      m_sp = (m_sp + 2) % 3;
      m_pc = m_stack[m_sp];
    end else if (jmp) begin
      if (psh) begin
        m_stack[m_sp] = m_pc;
        m_sp = (m_sp + 1) % 3;
      end
      m_pc = jaddr;
    end
    if (dcl) m_bank = dbank;
    // Controls outside their sampling state must be ignored.
    jump_i = 1'($urandom); push_i = 1'($urandom); pop_i = 1'($urandom);
    jump_addr_i = 12'($urandom); dcl_i = 1'($urandom); dcl_bank_i = 2'($urandom);
    d_i = 4'($urandom);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) phi2_edge();
      nib = 4'((m_pc >> (4 * k)) & 12'hF);
      check($sformatf("A%0d_bus pc=%03h", k + 1, m_pc), 32'(obs_bus()),
            32'(exp_bus(1'b1, nib, 1'b1, k == 2, (k == 2) ? onehot(m_bank) : 4'b0)));
    end
    phi2_edge();
    check("M1_bus", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b1, 1'b0, 4'b0)));
    d_i = op_hi;
    phi2_edge();
    check("M2_bus", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b1, 1'b0, 4'b0)));
    check("opr", 32'(opr_o), 32'(op_hi));
    d_i = op_lo;
    iv_cnt = 0;
    phi2_edge();
    check("X1_bus", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b1, 1'b0, 4'b0)));
    check("opa", 32'(opa_o), 32'(op_lo));
    check("instr_valid_clks", 32'(iv_cnt), 32'd1);
    d_i = 4'($urandom);
    src_i = src;
    phi2_edge();
    m_pc = m_pc + 12'd1;
    check("X2_bus", 32'(obs_bus()),
          32'(exp_bus(1'b0, 4'h0, 1'b1, 1'b0, src ? onehot(m_bank) : 4'b0)));
    src_i = 1'($urandom);
    dcl_i = 1'b0;
    phi2_edge();
    check("X3_bus", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b0, 1'b0, 4'b0)));
  endtask

  task automatic plain(input logic [3:0] hi, input logic [3:0] lo);
    run_cycle(hi, lo, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 2'd0);
  endtask

  task automatic jms(input logic [11:0] a);
    run_cycle(4'h5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, a, 1'b0, 2'd0);
  endtask

  task automatic jmp(input logic [11:0] a);
    run_cycle(4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, a, 1'b0, 2'd0);
  endtask

  task automatic bbl();
    run_cycle(4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 2'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic r_jmp, r_psh, r_pop, r_dcl, r_src;
    RESET_ni = 1'b0; phi2_i = 1'b0; d_i = '0;
    jump_i = 1'b0; jump_addr_i = '0; push_i = 1'b0; pop_i = 1'b0;
    dcl_i = 1'b0; dcl_bank_i = '0; src_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("reset_bus", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b0, 1'b0, 4'b0)));
    check("reset_opcode", 32'({opr_o, opa_o, instr_valid_o}), 32'd0);
    RESET_ni = 1'b1;
    @(negedge clk_i);

    // defaults, then opcode latch 5/A, then PC=1 visible
    plain(4'h5, 4'hA);
    plain(4'h1, 4'h2);

    // jump target nibbles 0,F,3
    jmp(12'h3F0);
    plain(4'h0, 4'h0);

    // PC carry across nibbles and full wrap
    jmp(12'h0FF);
    plain(4'h0, 4'h0);
    jmp(12'hFFF);
    plain(4'h0, 4'h0);
    plain(4'h0, 4'h0);

    // JMS / BBL
    jmp(12'h012);
    jms(12'h200);
    bbl();
    plain(4'h0, 4'h0);

    // four pushes into a 3-deep stack, then four pops
    jms(12'h100);
    jms(12'h200);
    jms(12'h300);
    jms(12'h400);
    bbl();
    bbl();
    bbl();
    bbl();
    plain(4'h0, 4'h0);

    // DCL bank 2 then SRC cycle
    run_cycle(4'hF, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 2'd2);
    run_cycle(4'h2, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 2'd0);

    // reset asserted in M1
    jump_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; dcl_i = 1'b0;
    repeat (4) phi2_edge();
    check("M1_before_reset", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b1, 1'b0, 4'b0)));
    RESET_ni = 1'b0;
    #1;
    check("midreset_bus", 32'(obs_bus()), 32'(exp_bus(1'b0, 4'h0, 1'b0, 1'b0, 4'b0)));
    check("midreset_opcode", 32'({opr_o, opa_o, instr_valid_o}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk_i);
    RESET_ni = 1'b1;
    @(negedge clk_i);
    plain(4'h3, 4'h3);
    bbl();

    // randomized cycles against the model
    for (int i = 0; i < 30; i++) begin
      r_pop = ($urandom_range(3) == 0);
      r_jmp = ($urandom_range(2) == 0);
      r_psh = 1'($urandom);
      r_dcl = ($urandom_range(3) == 0);
      r_src = 1'($urandom);
      run_cycle(4'($urandom), 4'($urandom), r_src, r_jmp, r_psh, r_pop,
                12'($urandom), r_dcl, 2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
